// File: rtl/MIPS_pkg.sv
// Shared types for the MIPS-16 data-memory arbiter: FSM states, read owner tags, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package MIPS_pkg;

    // Arbiter mode: normal core priority, or a single forced host grant
    typedef enum logic {
        S_NORMAL = 1'b0,
        S_FORCE  = 1'b1
    } arb_state_t;

    // Which requester a returning read belongs to
    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Wide enough for the largest supported wait limit (15)
    localparam int CNT_W = 4;

endpackage

// File: rtl/mips_16_starve_cnt.sv
// Host starvation counter: counts consecutive ungranted host-request cycles, saturating at MAX_WAIT.
// Latency: limit_next is combinational; the count itself updates on the next clk edge.
// Backpressure: none; wait_cyc low (request dropped or granted) clears the count.
module mips_16_starve_cnt
    import MIPS_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_cyc,
    output logic limit_next
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count;

    // Count consecutive waiting cycles; any non-waiting cycle restarts the count
    always_ff @(posedge clk) begin
        if (rst || !wait_cyc) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CNT_W'(1);
        end
    end

    // This waiting cycle brings the count to the limit, so the host is forced next cycle
    assign limit_next = wait_cyc && (count >= (LIMIT - CNT_W'(1)));

endmodule

// File: rtl/mips_16_dmem_arbiter.sv
// Data-memory arbiter between the MIPS-16 MEM stage and a host/debug port; optional starvation guard via DMEM_ARB_STARVE_EN.
// Latency: memory access issued in the request cycle; read data returned to its owner in the following cycle.
// Backpressure: core is stalled (c_stall_n=0) when not granted; host holds h_req until h_gnt.
module mips_16_dmem_arbiter
    import MIPS_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall_n,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    logic              host_gnt;
    logic              core_gnt;
    logic              force_host;
    logic              rd_pend;
    owner_t            rd_owner;
    logic              ret_core;
    logic              ret_host;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] h_rdata_q;

`ifdef DMEM_ARB_STARVE_EN
    arb_state_t state;
    logic       limit_next;

    mips_16_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (rst),
        .wait_cyc   (h_req && !host_gnt),
        .limit_next (limit_next)
    );

    // Enter the forced-grant mode when the host has waited MAX_WAIT cycles; leave after one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_NORMAL;
        end else begin
            case (state)
                S_NORMAL: state <= limit_next ? S_FORCE : S_NORMAL;
                S_FORCE:  state <= S_NORMAL;
                default:  state <= S_NORMAL;
            endcase
        end
    end

    assign force_host = (state == S_FORCE);
`else
    // Strict core priority: the wait limit has no effect in this build
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign force_host      = 1'b0;
`endif

    // Grant decision: host only when the core is idle, unless the host is being forced through
    assign host_gnt  = !rst && h_req && (force_host || !c_req);
    assign core_gnt  = !rst && c_req && !host_gnt;
    assign c_stall_n = rst || !c_req || core_gnt;
    assign h_gnt     = host_gnt;

    // Single memory port, driven by whichever requester won this cycle
    assign m_en    = host_gnt || core_gnt;
    assign m_we    = m_en && (host_gnt ? h_we : c_we);
    assign m_addr  = host_gnt ? h_addr : c_addr;
    assign m_wdata = host_gnt ? h_wdata : c_wdata;

    // A read issued last cycle returns now; reset discards it
    assign ret_core = !rst && rd_pend && (rd_owner == OWN_CORE);
    assign ret_host = !rst && rd_pend && (rd_owner == OWN_HOST);

    assign h_rvalid = ret_host;
    assign c_rdata  = rst ? '0 : (ret_core ? m_rdata : c_rdata_q);
    assign h_rdata  = rst ? '0 : (ret_host ? m_rdata : h_rdata_q);

    // Track the owner of an outstanding read and hold each requester's last returned word
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            rd_owner  <= OWN_CORE;
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            rd_pend <= m_en && !m_we;
            if (m_en) begin
                rd_owner <= host_gnt ? OWN_HOST : OWN_CORE;
            end
            if (ret_core) begin
                c_rdata_q <= m_rdata;
            end
            if (ret_host) begin
                h_rdata_q <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mips_16_dmem_arbiter.sv
// Bench for the data-memory arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: host stimulus holds its request until granted, with occasional early drops.
module tb_mips_16_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MW = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          c_req, c_we, h_req, h_we;
    logic [AW-1:0] c_addr, h_addr, m_addr;
    logic [DW-1:0] c_wdata, h_wdata, m_wdata, m_rdata;
    logic [DW-1:0] c_rdata, h_rdata;
    logic          c_stall_n, h_gnt, h_rvalid, m_en, m_we;

    int checks   = 0;
    int failures = 0;

    mips_16_dmem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_stall_n (c_stall_n),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .m_en      (m_en),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        logic [DW-1:0] w;
        w = (16'(a) * 16'h0101) ^ 16'h5A5A;
        if (a == 16'h10) w = 16'h1234;
        return w;
    endfunction

    // Synchronous RAM: read data one cycle after m_en; reloaded with known contents during reset
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            else      m_rdata     <= ram[m_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [DW-1:0] mdl_mem [256];
    int            waited;
    bit            pend, pend_host;
    logic [DW-1:0] pend_data, exp_c, exp_h;

    task automatic model_check();
        bit hg, cg, rv, any, we;
        logic [AW-1:0] a;
        if (rst) begin
            chk("rst_m_en", m_en, 0);
            chk("rst_h_gnt", h_gnt, 0);
            chk("rst_h_rvalid", h_rvalid, 0);
            chk("rst_c_stall_n", c_stall_n, 1);
            chk("rst_c_rdata", c_rdata, 0);
            chk("rst_h_rdata", h_rdata, 0);
            waited = 0;
            pend   = 0;
            exp_c  = '0;
            exp_h  = '0;
            for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);
            return;
        end
        rv = pend && pend_host;
        if (pend) begin
            if (pend_host) exp_h = pend_data;
            else           exp_c = pend_data;
        end
        hg  = h_req && (!c_req || (STARVE && waited >= MW));
        cg  = c_req && !hg;
        any = hg || cg;
        we  = hg ? h_we : c_we;
        a   = hg ? h_addr : c_addr;
        chk("m_en", m_en, any);
        chk("h_gnt", h_gnt, hg);
        chk("c_stall_n", c_stall_n, !(c_req && !cg));
        chk("h_rvalid", h_rvalid, rv);
        chk("c_rdata", c_rdata, exp_c);
        chk("h_rdata", h_rdata, exp_h);
        if (any) begin
            chk("m_we", m_we, we);
            chk("m_addr", m_addr, a);
            if (we) chk("m_wdata", m_wdata, hg ? h_wdata : c_wdata);
        end
        pend      = any && !we;
        pend_host = hg;
        if (pend) pend_data = mdl_mem[a];
        if (any && we) mdl_mem[a] = hg ? h_wdata : c_wdata;
        waited = (h_req && !hg) ? ((waited < MW) ? waited + 1 : MW) : 0;
    endtask

    // Compare process: checks every cycle, after inputs settle and before the next rising edge
    always @(negedge clk) begin
        #2;
        model_check();
    end

    task automatic drive(input logic r, input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic hr, input logic hw,
                         input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(negedge clk);
        rst = r; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        #3;
    endtask

    task automatic idle();
        drive(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    endtask

    initial begin
        bit            hpend, hw_r;
        logic [AW-1:0] ha_r;
        logic [DW-1:0] hd_r;

        rst = 1; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;

        // Reset with both requesters active: nothing may be issued
        repeat (3) drive(1, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
        chk("lit_rst_m_en", m_en, 0);
        chk("lit_rst_c_stall_n", c_stall_n, 1);
        chk("lit_rst_h_gnt", h_gnt, 0);
        chk("lit_rst_c_rdata", c_rdata, 0);

        // Core read of 0x10 with host idle
        drive(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
        chk("lit_core_rd_m_en", m_en, 1);
        chk("lit_core_rd_m_addr", m_addr, 8'h10);
        chk("lit_core_rd_stall_n", c_stall_n, 1);
        idle();
        chk("lit_core_rd_data", c_rdata, 16'h1234);

        // Host write then read-back of 0x20 with the core idle
        drive(0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'hBEEF);
        chk("lit_host_wr_gnt", h_gnt, 1);
        chk("lit_host_wr_m_we", m_we, 1);
        idle();
        chk("lit_host_wr_no_rvalid", h_rvalid, 0);
        drive(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000);
        chk("lit_host_rd_gnt", h_gnt, 1);
        idle();
        chk("lit_host_rd_rvalid", h_rvalid, 1);
        chk("lit_host_rd_data", h_rdata, 16'hBEEF);
        idle();
        chk("lit_host_rd_rvalid_pulse", h_rvalid, 0);
        chk("lit_host_rd_hold", h_rdata, 16'hBEEF);

        // Core held busy with a competing host read: forced grant on cycle MW+1 only with starvation guard
        for (int k = 1; k <= MW + 1; k++) begin
            drive(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
            chk($sformatf("lit_starve_gnt_c%0d", k), h_gnt, STARVE && (k == MW + 1));
            chk($sformatf("lit_starve_stall_c%0d", k), c_stall_n, !(STARVE && (k == MW + 1)));
        end
        drive(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
        chk("lit_starve_after_stall_n", c_stall_n, 1);
`ifdef DMEM_ARB_STARVE_EN
        chk("lit_starve_host_rvalid", h_rvalid, 1);
        chk("lit_starve_host_rdata", h_rdata, 16'hBEEF);
`endif

        // Reset the cycle after a host read grant discards that read
        drive(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h11, 16'h0000);
        chk("lit_rst_flight_gnt", h_gnt, 1);
        drive(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        chk("lit_rst_flight_rvalid", h_rvalid, 0);
        chk("lit_rst_flight_rdata", h_rdata, 0);
        chk("lit_rst_flight_m_en", m_en, 0);
        idle();
        chk("lit_rst_flight_after_rvalid", h_rvalid, 0);
        chk("lit_rst_flight_after_rdata", h_rdata, 0);

        // Host gives up after two waits; a fresh request must wait the full limit again
        repeat (2) begin
            drive(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h30, 16'h0000);
            chk("lit_drop_wait_gnt", h_gnt, 0);
        end
        drive(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h30, 16'h0000);
        chk("lit_drop_no_host_gnt", h_gnt, 0);
        chk("lit_drop_core_addr", m_addr, 8'h10);
        for (int k = 1; k <= MW + 1; k++) begin
            drive(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h30, 16'h0000);
            chk($sformatf("lit_drop_rewait_gnt_c%0d", k), h_gnt, STARVE && (k == MW + 1));
        end
        idle();

        // Randomized traffic on a small address window to provoke same-word conflicts
        hpend = 0; hw_r = 0; ha_r = '0; hd_r = '0;
        for (int n = 0; n < 3000; n++) begin
            bit r, cr;
            r  = ($urandom_range(0, 199) == 0);
            cr = ($urandom_range(0, 3) != 0);
            if (hpend && $urandom_range(0, 49) == 0) hpend = 0;
            if (!hpend && $urandom_range(0, 2) == 0) begin
                hpend = 1;
                hw_r  = $urandom_range(0, 1) != 0;
                ha_r  = AW'($urandom_range(8'h10, 8'h17));
                hd_r  = DW'($urandom);
            end
            drive(r, cr, $urandom_range(0, 2) == 0, AW'($urandom_range(8'h10, 8'h17)), DW'($urandom),
                  hpend, hw_r, ha_r, hd_r);
            if (r || h_gnt) hpend = 0;
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
